ctrlset_ff_pipe: RTL
====================

# ctrlset_ff_pipe

Parametrised multi-channel register pipeline for the slice control-set layer. Each channel is a chain of DEPTH registers, each WIDTH bits wide, with its own clock-enable and set/reset. Per-channel masks choose whether CE and SR are connected or tied off, and set SR polarity, SR value and SR-gated-by-CE mode. The block also exports the resolved per-channel CE/SR, so downstream packing logic sees exactly the control set the flops use.

## Interface
Parameters:
- CHANNELS, 4, number of independent channels (≥1)
- WIDTH, 8, bits per channel per stage (≥1)
- DEPTH, 2, register stages per channel (≥1)
- CE_USED, all ones (CHANNELS bits), bit c=1: ce[c] drives the channel; 0: CE tied high
- SR_USED, all ones (CHANNELS bits), bit c=1: sr[c] drives the channel; 0: SR tied inactive
- SR_INV, 0 (CHANNELS bits), bit c=1: sr[c] is active-low
- SR_GATED_BY_CE, 0 (CHANNELS bits), bit c=1: SR takes effect only when the effective CE is high (FDRE-style); 0: SR overrides CE
- INIT, 0 (CHANNELS*WIDTH bits), value loaded into every stage of a channel on rst; slice c = bits [c*WIDTH +: WIDTH]
- SRVAL, 0 (CHANNELS*WIDTH bits), value loaded into every stage of a channel on effective SR; same slicing

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high global reset
- ce  in  CHANNELS  per-channel clock enable
- sr  in  CHANNELS  per-channel set/reset (polarity per SR_INV)
- d  in  CHANNELS*WIDTH  channel data in, slice c for channel c
- q  out  CHANNELS*WIDTH  last-stage data, slice c for channel c
- ce_eff  out  CHANNELS  resolved CE, combinational
- sr_eff  out  CHANNELS  resolved, active-high SR, combinational

## Operation
- ce_eff[c] = CE_USED[c] ? ce[c] : 1.
- sr_eff[c] = SR_USED[c] ? (sr[c] ^ SR_INV[c]) : 0.
- Each stage register of channel c updates on the rising clk edge, using the first matching rule:
  1. rst=1: every stage loads INIT slice c. This overrides all other inputs on all channels.
  2. sr_eff[c]=1 and (SR_GATED_BY_CE[c]=0 or ce_eff[c]=1): every stage loads SRVAL slice c.
  3. ce_eff[c]=1: stage 0 loads d slice c, and stage k loads stage k-1 for 1≤k<DEPTH.
  4. Otherwise: all stages hold.
- q slice c = stage DEPTH-1 of channel c.
- Channels are fully independent. No cross-channel interaction except through rst.
- ce_eff and sr_eff do not depend on rst or state. They are valid in every cycle, including during reset.
- An SR that is gated out (gated mode with ce_eff=0) is dropped. It is not remembered.

## Timing
- Reset value: every stage and q = INIT. ce_eff and sr_eff follow their inputs.
- Latency d→q: DEPTH enabled cycles. Disabled cycles stall the chain without losing data.
- SR: q shows SRVAL on the cycle after the qualifying edge, and all stages are flushed at once. Data presented on that edge is discarded.
- SR and CE asserted on the same edge: SR wins in both modes.
- rst asserted mid-stream: all in-flight data is discarded. After rst deasserts, the chain needs DEPTH enabled cycles before q shows new d.
- rst and sr on the same edge: INIT wins.
- Tied-off CE: the channel shifts every cycle. Tied-off SR: sr[c] is ignored entirely.

## Test plan
The bench config for all scenarios is CHANNELS=2, WIDTH=8, DEPTH=2, INIT={8'h3C,8'hA5}, SRVAL={8'h00,8'hFF}, with ch0 = low slice.

- Reset: rst=1 for 1 cycle with random d/ce/sr -> q={3C,A5}. Then hold ce=0 for 5 cycles -> q unchanged.
- Pipeline latency: ch0 ce=1 every cycle, d=01,02,03 -> q0 shows 01 two edges after 01 is presented, then 02, 03. With ce low on the middle cycle, each value appears one cycle later and none is lost.
- SR override (SR_GATED_BY_CE=0): ch0 ce=0, sr=1 for one edge -> q0=FF on the next cycle. A following ce=1 with d=07 needs 2 edges to reach q0, with FF in between.
- SR gated (SR_GATED_BY_CE=2'b01): ch0 ce=0, sr=1 -> q0 unchanged. Then ce=1, sr=1 -> q0=FF. ch1 keeps shifting its own d independently throughout.
- Masks: CE_USED=2'b10, SR_USED=2'b10, SR_INV=2'b10 -> ce_eff[0]=1 and sr_eff[0]=0 for any ce[0]/sr[0]; ch0 shifts every cycle. Driving sr[1]=0 gives sr_eff[1]=1, and q1 goes to 00 on the next cycle.
- Reset priority: rst=1 and sr=2'b11 on the same edge, mid-stream -> q={3C,A5}. The next DEPTH enabled cycles still output INIT-flushed stages before new d appears.

Source files
------------

// File: rtl/ctrlset_ff_pipe.sv
// Multi-channel register pipeline with per-channel clock-enable and set/reset.
// Exports the resolved CE/SR so packing logic sees the same control set the flops use.
module ctrlset_ff_pipe #(
  parameter int unsigned                      CHANNELS       = 4,
  parameter int unsigned                      WIDTH          = 8,
  parameter int unsigned                      DEPTH          = 2,
  parameter logic [CHANNELS-1:0]              CE_USED        = '1,
  parameter logic [CHANNELS-1:0]              SR_USED        = '1,
  parameter logic [CHANNELS-1:0]              SR_INV         = '0,
  parameter logic [CHANNELS-1:0]              SR_GATED_BY_CE = '0,
  parameter logic [CHANNELS*WIDTH-1:0]        INIT           = '0,
  parameter logic [CHANNELS*WIDTH-1:0]        SRVAL          = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       ce,
  input  logic [CHANNELS-1:0]       sr,
  input  logic [CHANNELS*WIDTH-1:0] d,
  output logic [CHANNELS*WIDTH-1:0] q,
  output logic [CHANNELS-1:0]       ce_eff,
  output logic [CHANNELS-1:0]       sr_eff
);

  // Tied-off CE reads as always-enabled; tied-off SR reads as never-asserted.
  assign ce_eff = ce | ~CE_USED;
  assign sr_eff = (sr ^ SR_INV) & SR_USED;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    localparam logic [WIDTH-1:0] INIT_C  = INIT[c*WIDTH +: WIDTH];
    localparam logic [WIDTH-1:0] SRVAL_C = SRVAL[c*WIDTH +: WIDTH];

    logic [WIDTH-1:0] r_stage [DEPTH];
    logic             w_sr_take;

    // In gated mode an SR seen while CE is low is simply dropped.
    assign w_sr_take = sr_eff[c] & (~SR_GATED_BY_CE[c] | ce_eff[c]);

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k < DEPTH; k++) r_stage[k] <= INIT_C;
      end else if (w_sr_take) begin
        for (int k = 0; k < DEPTH; k++) r_stage[k] <= SRVAL_C;
      end else if (ce_eff[c]) begin
        r_stage[0] <= d[c*WIDTH +: WIDTH];
        for (int k = 1; k < DEPTH; k++) r_stage[k] <= r_stage[k-1];
      end
    end

    assign q[c*WIDTH +: WIDTH] = r_stage[DEPTH-1];
  end

endmodule
